// File: rtl/rotate_monitor.sv
// Monitors a rotating one-hot pattern: locks on the first legal one-hot value, then checks
// rotation order and per-value hold time, flagging SEQ / TIMING / STALL errors until cleared.
module rotate_monitor #(
    parameter int PERIOD = 25000,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in,
    input  logic       clr,
    output logic [1:0] pos,
    output logic       valid,
    output logic       step,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] rot_count
);

    typedef enum logic [1:0] {IDLE, LOCKED, ERROR} state_t;

    localparam logic [1:0] E_SEQ   = 2'b01;
    localparam logic [1:0] E_TIME  = 2'b10;
    localparam logic [1:0] E_STALL = 2'b11;

    state_t           state;
    logic [3:0]       in_q;
    logic [3:0]       prev;
    logic [CNT_W-1:0] cnt;
    logic             first;

    logic             onehot;
    logic             legal;
    logic             at_period;
    logic [1:0]       idx;

    assign onehot    = (in_q != 4'b0000) && ((in_q & (in_q - 4'd1)) == 4'b0000);
    assign legal     = (in_q == {prev[2:0], prev[3]});
    assign at_period = (cnt == CNT_W'(PERIOD));

    always_comb begin
        idx = 2'd0;
        case (in_q)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_q      <= 4'b0000;
            prev      <= 4'b0000;
            cnt       <= '0;
            first     <= 1'b0;
            pos       <= 2'd0;
            valid     <= 1'b0;
            step      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            rot_count <= 8'd0;
        end else begin
            in_q <= in;
            step <= 1'b0;
            case (state)
                IDLE: begin
                    if (onehot) begin
                        state     <= LOCKED;
                        prev      <= in_q;
                        pos       <= idx;
                        valid     <= 1'b1;
                        cnt       <= CNT_W'(1);
                        rot_count <= 8'd0;
                        first     <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (in_q == prev) begin
                        // Holding past PERIOD is a stall; counter saturates at PERIOD
                        if (at_period) begin
                            state    <= ERROR;
                            valid    <= 1'b0;
                            err      <= 1'b1;
                            err_code <= E_STALL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (!legal) begin
                        state    <= ERROR;
                        valid    <= 1'b0;
                        err      <= 1'b1;
                        err_code <= E_SEQ;
                    end else if (first || at_period) begin
                        // First interval after lock may be short: lock point is arbitrary
                        step      <= 1'b1;
                        pos       <= pos + 2'd1;
                        rot_count <= rot_count + 8'd1;
                        prev      <= in_q;
                        cnt       <= CNT_W'(1);
                        first     <= 1'b0;
                    end else begin
                        state    <= ERROR;
                        valid    <= 1'b0;
                        err      <= 1'b1;
                        err_code <= E_TIME;
                    end
                end
                ERROR: begin
                    if (clr) begin
                        state    <= IDLE;
                        err      <= 1'b0;
                        err_code <= 2'b00;
                        cnt      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_monitor.sv
// Bench for rotate_monitor (PERIOD=4): directed vector table, async-reset sequence,
// then randomized rotation streams checked against an index/run-length reference model.
module tb_rotate_monitor;

    localparam int PERIOD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in = 4'b0000;
    logic       clr = 1'b0;
    logic [1:0] pos;
    logic       valid, step, err;
    logic [1:0] err_code;
    logic [7:0] rot_count;

    int n_checks = 0;
    int n_fail   = 0;

    rotate_monitor #(.PERIOD(PERIOD), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .clr(clr),
        .pos(pos), .valid(valid), .step(step), .err(err),
        .err_code(err_code), .rot_count(rot_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] in;
        logic       clr;
        logic [1:0] pos;
        logic       valid, step, err;
        logic [1:0] code;
        logic [7:0] rot;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [14:0] outs();
        return {pos, valid, step, err, err_code, rot_count};
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pos=%0d valid=%b step=%b err=%b code=%b rot=%0d, want pos=%0d valid=%b step=%b err=%b code=%b rot=%0d",
                     name, act[14:13], act[12], act[11], act[10], act[9:8], act[7:0],
                     exp[14:13], exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
        end
    endtask

    task automatic add(input logic [3:0] i, input logic c, input logic [1:0] p, input logic v,
                       input logic s, input logic e, input logic [1:0] cd, input logic [7:0] r);
        vec_t t;
        t.in = i; t.clr = c; t.pos = p; t.valid = v; t.step = s; t.err = e; t.code = cd; t.rot = r;
        tbl.push_back(t);
    endtask

    // Reference model: tracks locked index and how long it has been seen, one cycle behind in
    logic [3:0] m_inq;
    bit         m_lock, m_errst, m_first, m_step, m_valid, m_err;
    int         m_idx, m_held, m_rot, m_pos;
    logic [1:0] m_code;

    function automatic void m_reset();
        m_inq = 4'b0; m_lock = 0; m_errst = 0; m_first = 0; m_step = 0; m_valid = 0; m_err = 0;
        m_idx = 0; m_held = 0; m_rot = 0; m_pos = 0; m_code = 2'b00;
    endfunction

    function automatic void m_fail(input logic [1:0] c);
        m_lock = 0; m_errst = 1; m_valid = 0; m_err = 1; m_code = c;
    endfunction

    function automatic void m_clock(input logic [3:0] d, input logic c);
        m_step = 0;
        if (m_errst) begin
            if (c) begin m_errst = 0; m_err = 0; m_code = 2'b00; end
        end else if (!m_lock) begin
            if ($countones(m_inq) == 1) begin
                for (int b = 0; b < 4; b++) if (m_inq[b]) m_idx = b;
                m_lock = 1; m_pos = m_idx; m_valid = 1; m_held = 1; m_rot = 0; m_first = 1;
            end
        end else begin
            if (m_inq == 4'(1 << m_idx)) begin
                if (m_held == PERIOD) m_fail(2'b11); else m_held++;
            end else if (m_inq != 4'(1 << ((m_idx + 1) % 4))) begin
                m_fail(2'b01);
            end else if (m_first || m_held == PERIOD) begin
                m_idx = (m_idx + 1) % 4; m_pos = m_idx; m_rot = (m_rot + 1) % 256;
                m_held = 1; m_first = 0; m_step = 1;
            end else begin
                m_fail(2'b10);
            end
        end
        m_inq = d;
    endfunction

    function automatic logic [14:0] m_outs();
        return {2'(m_pos), m_valid, m_step, m_err, m_code, 8'(m_rot)};
    endfunction

    task automatic mcycle(input logic [3:0] d, input logic c, input string name);
        in = d; clr = c;
        @(posedge clk);
        m_clock(d, c);
        #1;
        chk(name, outs(), m_outs());
    endtask

    initial begin
        // in, clr -> pos, valid, step, err, code, rot (after the edge that follows)
        add(4'b1000,0, 0,0,0,0,2'b00,0); add(4'b1000,0, 3,1,0,0,2'b00,0);
        add(4'b1000,0, 3,1,0,0,2'b00,0); add(4'b1000,0, 3,1,0,0,2'b00,0);
        add(4'b0001,0, 3,1,0,0,2'b00,0); add(4'b0001,0, 0,1,1,0,2'b00,1);
        add(4'b0001,0, 0,1,0,0,2'b00,1); add(4'b0001,0, 0,1,0,0,2'b00,1);
        add(4'b0010,0, 0,1,0,0,2'b00,1); add(4'b0010,0, 1,1,1,0,2'b00,2);
        add(4'b0010,0, 1,1,0,0,2'b00,2); add(4'b0010,0, 1,1,0,0,2'b00,2);
        add(4'b0100,0, 1,1,0,0,2'b00,2); add(4'b0100,0, 2,1,1,0,2'b00,3);
        add(4'b0100,0, 2,1,0,0,2'b00,3); add(4'b0100,0, 2,1,0,0,2'b00,3);
        add(4'b1000,0, 2,1,0,0,2'b00,3); add(4'b1000,0, 3,1,1,0,2'b00,4);
        add(4'b1000,0, 3,1,0,0,2'b00,4); add(4'b1000,0, 3,1,0,0,2'b00,4);
        add(4'b1000,0, 3,1,0,0,2'b00,4); add(4'b1000,0, 3,0,0,1,2'b11,4);   // stall
        add(4'b0100,1, 3,0,0,0,2'b00,4); add(4'b0100,0, 2,1,0,0,2'b00,0);   // clear, relock pos 2
        add(4'b1000,0, 2,1,0,0,2'b00,0); add(4'b1000,0, 3,1,1,0,2'b00,1);   // short first interval
        add(4'b0001,0, 3,1,0,0,2'b00,1); add(4'b0001,0, 3,0,0,1,2'b10,1);   // timing
        add(4'b0001,0, 3,0,0,1,2'b10,1); add(4'b0001,1, 3,0,0,0,2'b00,1);
        add(4'b0010,0, 0,1,0,0,2'b00,0); add(4'b0010,0, 1,1,1,0,2'b00,1);
        add(4'b0001,1, 1,1,0,0,2'b00,1); add(4'b0001,0, 1,0,0,1,2'b01,1);   // clr ignored, backward
        add(4'b0011,1, 1,0,0,0,2'b00,1); add(4'b0011,0, 1,0,0,0,2'b00,1);
        add(4'b0000,0, 1,0,0,0,2'b00,1); add(4'b0010,1, 1,0,0,0,2'b00,1);   // idle ignores junk/clr
        add(4'b0011,0, 1,1,0,0,2'b00,0); add(4'b0011,0, 1,0,0,1,2'b01,0);   // multi-hot

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", outs(), 15'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            in = tbl[k].in; clr = tbl[k].clr;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", k), outs(),
                {tbl[k].pos, tbl[k].valid, tbl[k].step, tbl[k].err, tbl[k].code, tbl[k].rot});
        end

        // Async reset mid-lock with rot_count=7, then relock
        rst_n = 1'b0; #2; rst_n = 1'b1;
        m_reset();
        in = 4'b0001; clr = 1'b0;
        for (int s = 0; s < 8; s++)
            for (int h = 0; h < PERIOD; h++)
                mcycle(4'(1 << (s % 4)), 1'b0, "walk7");
        chk("rot_is_7", {7'd0, rot_count}, {7'd0, 8'd7});
        #2; rst_n = 1'b0; #1;
        chk("async_reset", outs(), 15'd0);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mcycle(4'b0100, 1'b0, "relock_a");
        mcycle(4'b0100, 1'b0, "relock_b");
        chk("relock_rot0", {pos, valid, rot_count}, {2'd2, 1'b1, 8'd0});

        // Randomized streams against the model
        begin
            logic [3:0] cur;
            int         left;
            cur = 4'b0100; left = 2;
            for (int n = 0; n < 3000; n++) begin
                logic c;
                if (left == 0) begin
                    if ($urandom_range(0, 9) == 0) cur = 4'($urandom_range(0, 15));
                    else cur = (cur == 4'b0) ? 4'b0001 : {cur[2:0], cur[3]};
                    left = ($urandom_range(0, 9) < 6) ? PERIOD : $urandom_range(1, 6);
                end
                left--;
                c = m_errst ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 199) == 0) begin
                    #2; rst_n = 1'b0; #1;
                    chk("rand_async_reset", outs(), 15'd0);
                    m_reset();
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                end else begin
                    mcycle(cur, c, "random");
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rotate_monitor.md
ROTATE_MONITOR -- requirements
Module: rotate_monitor

Interface
REQ-001 Parameter PERIOD, default 25000, required hold time of each one-hot value in clk cycles; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, width of the internal hold-interval counter; SHALL satisfy 2**CNT_W > PERIOD.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in  input  4  rotating one-hot pattern from the rotate driver, synchronous to clk.
REQ-006 clr  input  1  synchronous error-clear pulse; meaningful only in ERROR state.
REQ-007 pos  output  2  index of the set bit of the currently locked pattern (0..3).
REQ-008 valid  output  1  high while locked onto a legal rotation.
REQ-009 step  output  1  one-cycle pulse per legal rotation step.
REQ-010 err  output  1  sticky error flag.
REQ-011 err_code  output  2  00 none, 01 SEQ, 10 TIMING, 11 STALL.
REQ-012 rot_count  output  8  count of legal steps since lock, wraps 255->0.

Function
REQ-013 in SHALL be registered once into in_q; all decisions use in_q, and prev, the in_q value held from the previous accepted pattern.
REQ-014 Legal step: in_q equals prev rotated left by one (bit i -> bit i+1, bit 3 -> bit 0), e.g. 1000->0001->0010->0100->1000.
REQ-015 FSM states IDLE, LOCKED, ERROR; reset state IDLE.
REQ-016 IDLE: when in_q has exactly one bit set -> LOCKED, prev=in_q, pos=index of set bit, valid=1, hold counter=1, rot_count=0, first_interval=1.
REQ-017 IDLE with in_q zero or multi-hot: remain IDLE, outputs unchanged, no error.
REQ-018 LOCKED, in_q==prev, counter<PERIOD: counter increments.
REQ-019 LOCKED, in_q==prev, counter==PERIOD: -> ERROR, err_code=STALL.
REQ-020 LOCKED, in_q!=prev and not a legal step (zero, multi-hot, backward, skip): -> ERROR, err_code=SEQ; SEQ has priority over TIMING.
REQ-021 LOCKED, legal step, counter==PERIOD (or first_interval=1 and counter<=PERIOD): step=1 for one cycle, pos=pos+1 mod 4, rot_count+1 mod 256, prev=in_q, counter=1, first_interval=0.
REQ-022 LOCKED, legal step, first_interval=0 and counter<PERIOD: -> ERROR, err_code=TIMING.
REQ-023 On entry to ERROR: valid=0, err=1, step=0; pos and rot_count frozen.
REQ-024 ERROR: err and err_code held until clr=1 sampled, then -> IDLE, err=0, err_code=00, counter=0; all else held.
REQ-025 clr outside ERROR SHALL be ignored.
REQ-026 Latency: a change on in is reflected in step/pos/err at the second rising edge after it is presented.
REQ-027 Counter SHALL never exceed PERIOD; no wrap of the hold counter is permitted.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, in_q=0, prev=0, counter=0, first_interval=0, pos=0, valid=0, step=0, err=0, err_code=00, rot_count=0.
REQ-029 Reset asserted mid-interval or in ERROR SHALL discard all history; after release, lock is reacquired per REQ-016.
REQ-030 rst_n deassertion SHALL be released synchronously to clk by the integrator; the block does no internal synchronisation of rst_n.

Verification (PERIOD=4)
REQ-031 in=1000 from reset release, then 0001,0010,0100,1000 each held 4 cycles -> valid=1, pos 3,0,1,2,3, four step pulses, rot_count=4, err=0.
REQ-032 Lock on 1000 held 2 cycles only, then legal 0001 -> first-interval step accepted, step=1, pos=0, no error.
REQ-033 Locked, 0001 held 3 cycles then 0010 -> err=1, err_code=10, valid=0, pos stays 0.
REQ-034 Locked on 0010, in changes to 0001 (backward) or 0011 -> err_code=01; 0010 held 5 cycles -> err_code=11.
REQ-035 In ERROR, pulse clr with in=0100 -> next cycle IDLE, err=0, then relock with pos=2, rot_count=0.
REQ-036 rst_n pulsed low during LOCKED with rot_count=7 -> all outputs 0 asynchronously, relock after release with rot_count=0.
